// File: rtl/seq_mult_hs_if.sv
// seq_mult_hs_if: operand/request and product/status signals of the sequential multiplier.
// Latency: none, this is wiring only. The master drives start/is_signed/a/b, and the slave returns busy/done/p.
// Backpressure: the master waits for done. A start issued while busy is dropped by the slave.
interface seq_mult_hs_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic                 is_signed;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   p;

    // Controller side: issues one multiply and waits for done.
    modport master (
        output start,
        output is_signed,
        output a,
        output b,
        input  busy,
        input  done,
        input  p
    );

    // Multiplier side.
    modport slave (
        input  start,
        input  is_signed,
        input  a,
        input  b,
        output busy,
        output done,
        output p
    );
endinterface

// File: rtl/seq_mult_hs.sv
// seq_mult_hs: shift-add multiplier, signed/unsigned selectable per operation; optional SEQ_MULT_EARLY_EXIT_EN.
// Latency: start->done is WIDTH+1 cycles. With SEQ_MULT_EARLY_EXIT_EN, it is N+1 cycles, where N is the highest set bit of b plus 1 (at least 1).
// Backpressure: start is accepted only in IDLE/DONE. Starts seen during busy are dropped. p holds until the next done.
module seq_mult_hs #(
    parameter int WIDTH = 8,
    parameter int CTR_W = $clog2(WIDTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    seq_mult_hs_if.slave  mul
);

    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       mcand_q, mcand_d;
    logic [WIDTH-1:0]    mplier_q, mplier_d;
    logic                signed_q, signed_d;
    logic [PW-1:0]       acc_q, acc_d;
    logic [CTR_W-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]       p_q, p_d;

    logic                accept;
    logic                at_msb;
    logic                cur_bit;
    logic                last_step;
    logic [PW-1:0]       partial;
    logic [PW-1:0]       acc_step;

    // A new request is taken whenever the unit is not mid-run, including the DONE cycle (back-to-back).
    assign accept  = mul.start && (state_q != S_RUN);
    assign at_msb  = (cnt_q == CTR_W'(WIDTH - 1));
    assign cur_bit = |(mplier_q & (WIDTH'(1) << cnt_q));
    assign partial = mcand_q << cnt_q;

    // One multiplier bit per cycle. In signed mode the MSB carries weight -2^(WIDTH-1), so its partial product is subtracted.
    always_comb begin
        acc_step = acc_q;
        if (cur_bit) begin
            if (signed_q && at_msb) begin
                acc_step = acc_q - partial;
            end else begin
                acc_step = acc_q + partial;
            end
        end
    end

`ifdef SEQ_MULT_EARLY_EXIT_EN
    logic [WIDTH-1:0] mplier_rest;

    // Stop as soon as no set multiplier bits remain above the current one. A negative signed b keeps its MSB set, so it runs full length.
    always_comb begin
        mplier_rest = (mplier_q >> cnt_q) >> 1;
        last_step   = at_msb || (mplier_rest == '0);
    end
`else
    // Fixed latency: always walk every multiplier bit.
    always_comb begin
        last_step = at_msb;
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. DONE lasts exactly one cycle, which makes done a single-cycle pulse.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (mul.start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (last_step) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = mul.start ? S_RUN : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath next state. Operands are captured on accept, the accumulator steps in RUN, and p loads only on the final step.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        signed_d = signed_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        if (accept) begin
            if (mul.is_signed) begin
                mcand_d = {{WIDTH{mul.a[WIDTH-1]}}, mul.a};
            end else begin
                mcand_d = {{WIDTH{1'b0}}, mul.a};
            end
            mplier_d = mul.b;
            signed_d = mul.is_signed;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (state_q == S_RUN) begin
            acc_d = acc_step;
            cnt_d = cnt_q + CTR_W'(1);
            if (last_step) begin
                p_d = acc_step;
            end
        end
    end

    // Datapath registers. Reset aborts any run in progress and clears the held product.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            signed_q <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            signed_q <= signed_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
        end
    end

    // Status and product are decoded straight from registers, so they are glitch-free.
    assign mul.busy = (state_q == S_RUN);
    assign mul.done = (state_q == S_DONE);
    assign mul.p    = p_q;

endmodule
